// File: rtl/apb_rr_master_pkg.sv
// Shared types and defaults for the round-robin APB master: transfer phase
// encoding, default widths and a small index helper.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Next requester index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above ptr,
// wrapping past the top index. Purely combinational.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned; without it this block would infer latches.
    grant = '0;
    idx   = '0;
    cand  = 0;
    // Scan from the farthest offset down so the closest hit to ptr is the
    // last one written and therefore wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (en && req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing one completer between NUM_REQ requesters: round-robin
// accept in IDLE, SETUP/ACCESS sequencing, pready timeout, one-hot response.
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant_idx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic               arb_en;
  logic               done;

  // Gating with rst keeps req_ready low while reset is held, not only after.
  assign arb_en    = (state == IDLE) && !rst;
  assign req_ready = grant;
  assign done      = pready || (cnt == CNT_W'(TIMEOUT - 1));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (grant_idx)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            owner   <= grant_idx;
            ptr     <= IDX_W'(wrap_inc(int'(grant_idx), NUM_REQ));
            pwrite  <= req_write[grant_idx];
            paddr   <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            pwdata  <= req_wdata[grant_idx*DATA_W +: DATA_W];
            psel    <= 1'b1;
            penable <= 1'b0;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            cnt       <= '0;
            rsp_valid <= NUM_REQ'(1) << owner;
            // pready takes priority over a timeout landing in the same cycle.
            rsp_err   <= pready ? pslverr : 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Randomized scoreboard bench for apb_rr_master with a behavioural APB RAM
// completer (optional wait states, out-of-range error, forced stall).
module tb_apb_rr_master;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 64;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, pwdata, prdata;
  logic                      rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0]         paddr;

  always #5 clk = ~clk;

  apb_rr_master #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // ---------------- completer (apb_ram stand-in) ----------------
  logic              presetn;
  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic              stall = 1'b0;
  int                wait_fixed = -1;
  int                wait_cur = 0;
  int                wcnt;
  logic              ram_oor;

  assign presetn = ~rst;
  assign ram_oor = paddr >= ADDR_W'(DEPTH * 4);
  assign pready  = psel && penable && !stall && (wcnt >= wait_cur);
  assign pslverr = pready && ram_oor;
  assign prdata  = (pready && !pwrite && !ram_oor) ? ram_mem[paddr[7:2]] : '0;

  always @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      wcnt <= 0;
    end else begin
      if (psel && !penable) begin
        wcnt     <= 0;
        wait_cur <= (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 3));
      end else if (psel && penable && !pready) begin
        wcnt <= wcnt + 1;
      end
      if (pready && pwrite && !ram_oor) ram_mem[paddr[7:2]] <= pwdata;
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  // Round-robin rule: first valid requester found scanning upward from p.
  function automatic logic [NUM_REQ-1:0] model_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return onehot((p + k) % NUM_REQ);
    return '0;
  endfunction

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  typedef struct {
    int                owner;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              to;
  } exp_t;

  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } cmd_t;

  exp_t              exp_q[$];
  cmd_t              cmd_q[NUM_REQ][$];
  int                accept_log[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                mptr = 0;
  bit                in_flight = 0;
  int                since_acc = 0;
  int                access_cycles = 0;
  int                cyc = 0;
  int                acc_cyc = 0;
  logic [ADDR_W-1:0] exp_paddr;
  logic              exp_pwrite;
  logic [DATA_W-1:0] exp_pwdata;
  int                last_owner = -1;
  logic [DATA_W-1:0] last_rdata;
  logic              last_err;
  int                last_latency;

  task automatic reset_model();
    exp_q.delete();
    accept_log.delete();
    in_flight     = 0;
    mptr          = 0;
    since_acc     = 0;
    access_cycles = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [NUM_REQ-1:0] exp_rdy;
    exp_t               e;
    int                 w;
    logic [ADDR_W-1:0]  a;
    logic [DATA_W-1:0]  d;
    logic               oor;
    cyc++;
    if (!rst) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, '0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_owner", rsp_valid, onehot(e.owner));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
          if (e.to) check("timeout_access_cycles", access_cycles, TIMEOUT);
          last_owner   = idx_of(rsp_valid);
          last_rdata   = rsp_rdata;
          last_err     = rsp_err;
          last_latency = cyc - acc_cyc;
        end
        in_flight = 0;
      end
      if (in_flight) begin
        since_acc++;
        if (since_acc == 1) begin
          check("setup_phase", {psel, penable}, 2'b10);
          check("setup_paddr", paddr, exp_paddr);
          check("setup_pwrite", pwrite, exp_pwrite);
          if (exp_pwrite) check("setup_pwdata", pwdata, exp_pwdata);
        end else begin
          access_cycles++;
          check("access_phase", {psel, penable}, 2'b11);
          check("access_paddr_stable", paddr, exp_paddr);
          check("access_within_timeout", access_cycles <= TIMEOUT, 1);
        end
      end else begin
        check("idle_no_psel", {psel, penable}, 2'b00);
      end
      exp_rdy = in_flight ? '0 : model_pick(req_valid, mptr);
      check("req_ready", req_ready, exp_rdy);
      if (exp_rdy != '0) begin
        w   = idx_of(exp_rdy);
        a   = req_addr[w*ADDR_W +: ADDR_W];
        d   = req_wdata[w*DATA_W +: DATA_W];
        oor = a >= ADDR_W'(DEPTH * 4);
        e.owner = w;
        e.to    = stall;
        if (stall) begin
          e.rdata = '0;
          e.err   = 1'b1;
        end else if (req_write[w]) begin
          if (!oor) ref_mem[a[7:2]] = d;
          e.rdata = '0;
          e.err   = oor;
        end else begin
          e.rdata = oor ? '0 : ref_mem[a[7:2]];
          e.err   = oor;
        end
        exp_q.push_back(e);
        accept_log.push_back(w);
        mptr          = (w + 1) % NUM_REQ;
        in_flight     = 1;
        since_acc     = 0;
        access_cycles = 0;
        acc_cyc       = cyc;
        exp_paddr     = a;
        exp_pwrite    = req_write[w];
        exp_pwdata    = d;
      end
    end
  end

  // ---------------- requester driver ----------------
  initial begin : driver
    logic [NUM_REQ-1:0] hs;
    cmd_t               c;
    forever begin
      @(negedge clk);
      hs = rst ? '0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] || !req_valid[i]) begin
          if (cmd_q[i].size() > 0) begin
            c = cmd_q[i].pop_front();
            req_valid[i]                   = 1'b1;
            req_write[i]                   = c.w;
            req_addr[i*ADDR_W +: ADDR_W]   = c.a;
            req_wdata[i*DATA_W +: DATA_W]  = c.d;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic push(input int i, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_t c;
    c.w = w;
    c.a = a;
    c.d = d;
    cmd_q[i].push_back(c);
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) if (cmd_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      #1;
      done = (req_valid == '0) && (exp_q.size() == 0) && !in_flight && queues_empty();
    end
    check({name, "_drain"}, done, 1);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2 rst = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int fair4[5];
    int fair2[4];
    bit seen;
    fair4 = '{0, 1, 2, 3, 0};
    fair2 = '{0, 2, 0, 2};
    rst = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset held, then asynchronous assertion mid-cycle.
    #1;
    check("rst_psel", {psel, penable}, 2'b00);
    check("rst_req_ready", req_ready, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_psel", {psel, penable}, 2'b00);
    check("rst_hold_rsp_valid", rsp_valid, '0);
    check("rst_hold_req_ready", req_ready, '0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    reset_model();
    #1;
    check("async_rst_psel", {psel, penable}, 2'b00);
    check("async_rst_rsp_valid", rsp_valid, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Write then read back, zero wait states.
    wait_fixed = 0;
    push(0, 1'b1, 32'd8, 32'h1234_5678);
    drain("t2_write");
    check("t2_write_owner", last_owner, 0);
    check("t2_write_err", last_err, 0);
    check("t2_write_latency", last_latency, 3);
    push(1, 1'b0, 32'd8, $urandom);
    drain("t2_read");
    check("t2_read_owner", last_owner, 1);
    check("t2_read_data", last_rdata, 32'h1234_5678);
    check("t2_read_latency", last_latency, 3);
    wait_fixed = -1;

    // Fairness with all four held, then only 0 and 2.
    reset_dut();
    push(0, 1'b0, 32'd0, 32'd0);
    push(0, 1'b0, 32'd4, 32'd0);
    for (int i = 1; i < NUM_REQ; i++) push(i, 1'b0, 32'(i * 4), 32'd0);
    drain("t3_fair4");
    check("t3_fair4_count", accept_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < accept_log.size()) check("t3_fair4_order", accept_log[k], fair4[k]);
    reset_dut();
    push(0, 1'b0, 32'd0, 32'd0);
    push(2, 1'b0, 32'd4, 32'd0);
    push(0, 1'b0, 32'd8, 32'd0);
    push(2, 1'b0, 32'd12, 32'd0);
    drain("t3_fair2");
    check("t3_fair2_count", accept_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < accept_log.size()) check("t3_fair2_order", accept_log[k], fair2[k]);

    // Out-of-range read returns pslverr.
    push(2, 1'b0, 32'h400, 32'd0);
    drain("t4_err");
    check("t4_err_flag", last_err, 1);
    check("t4_err_owner", last_owner, 2);

    // Stalled completer -> timeout, then a normal transfer.
    stall = 1'b1;
    push(3, 1'b0, 32'd4, 32'd0);
    drain("t5_timeout");
    check("t5_timeout_err", last_err, 1);
    check("t5_timeout_rdata", last_rdata, 0);
    stall = 1'b0;
    push(3, 1'b0, 32'd8, 32'd0);
    drain("t5_after");
    check("t5_after_err", last_err, 0);
    check("t5_after_rdata", last_rdata, 32'h1234_5678);

    // Reset during ACCESS; held requests restart from requester 0.
    reset_dut();
    stall = 1'b1;
    push(1, 1'b0, 32'd0, 32'd0);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = psel && penable;
    end
    check("t6_reach_access", seen, 1);
    for (int i = 0; i < NUM_REQ; i++) push(i, 1'b0, 32'(i * 4), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    reset_model();
    #1;
    check("t6_rst_psel", {psel, penable}, 2'b00);
    check("t6_rst_rsp_valid", rsp_valid, '0);
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    drain("t6_after");
    check("t6_count", accept_log.size(), 4);
    if (accept_log.size() > 1) begin
      check("t6_first", accept_log[0], 0);
      check("t6_second", accept_log[1], 1);
    end

    // Randomized mixed traffic.
    for (int n = 0; n < 80; n++) begin
      int i;
      logic [ADDR_W-1:0] a;
      i = $urandom_range(0, NUM_REQ - 1);
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 32'h400;
      push(i, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    drain("t7_random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
